// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//
// Instruction-decode stage of a pipelined RV32 datapath. Extracts fields,
// generates the sign-extended immediate, reads the register file, detects
// load-use hazards against the instruction in EX and holds the ID/EX register.
//
// Optional feature (compile-time macro WB_BYPASS_EN):
//   defined   : a same-cycle writeback to a read register replaces the stale
//               register file data in the captured operand.
//   undefined : operands come straight from the register file (x0 forced to 0).
//
// Ports:
//   clk, reset          pipeline clock, synchronous active-high reset
//   if_valid/instr/pc   IF/ID slot contents
//   flush               squash the instruction currently in decode
//   stall_out           load-use stall request to IF and IF/ID (combinational)
//   rf_read_addr_1/2    register file read addresses (combinational from instr)
//   rf_read_data_1/2    register file read data (combinational)
//   wb_write_*          writeback port, observed for the optional bypass
//   ex_*                registered ID/EX outputs
// -----------------------------------------------------------------------------
module decode_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_valid,
    input  logic [DATA_WIDTH-1:0] if_instr,
    input  logic [DATA_WIDTH-1:0] if_pc,
    input  logic                  flush,
    output logic                  stall_out,
    output logic [ADDR_BITS-1:0]  rf_read_addr_1,
    output logic [ADDR_BITS-1:0]  rf_read_addr_2,
    input  logic [DATA_WIDTH-1:0] rf_read_data_1,
    input  logic [DATA_WIDTH-1:0] rf_read_data_2,
    input  logic                  wb_write_enable,
    input  logic [ADDR_BITS-1:0]  wb_write_addr,
    input  logic [DATA_WIDTH-1:0] wb_write_data,
    output logic                  ex_valid,
    output logic [DATA_WIDTH-1:0] ex_pc,
    output logic [DATA_WIDTH-1:0] ex_rs1_data,
    output logic [DATA_WIDTH-1:0] ex_rs2_data,
    output logic [DATA_WIDTH-1:0] ex_imm,
    output logic [ADDR_BITS-1:0]  ex_rs1,
    output logic [ADDR_BITS-1:0]  ex_rs2,
    output logic [ADDR_BITS-1:0]  ex_rd,
    output logic [6:0]            ex_opcode,
    output logic [2:0]            ex_funct3,
    output logic                  ex_funct7_b5,
    output logic                  ex_mem_read,
    output logic                  ex_reg_write
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] rs1_data;
        logic [DATA_WIDTH-1:0] rs2_data;
        logic [DATA_WIDTH-1:0] imm;
        logic [ADDR_BITS-1:0]  rs1;
        logic [ADDR_BITS-1:0]  rs2;
        logic [ADDR_BITS-1:0]  rd;
        logic [6:0]            opcode;
        logic [2:0]            funct3;
        logic                  funct7_b5;
        logic                  mem_read;
        logic                  reg_write;
    } idex_t;

    // Register-file operand selection: x0 reads as zero, optional writeback bypass.
    function automatic logic [DATA_WIDTH-1:0] select_operand(
        input logic [ADDR_BITS-1:0]  addr,
        input logic [DATA_WIDTH-1:0] rf_data,
        input logic                  wb_en,
        input logic [ADDR_BITS-1:0]  wb_addr,
        input logic [DATA_WIDTH-1:0] wb_data
    );
        logic [DATA_WIDTH-1:0] result;
        if (addr == {ADDR_BITS{1'b0}}) begin
            result = {DATA_WIDTH{1'b0}};
`ifdef WB_BYPASS_EN
        end else if (wb_en && (wb_addr == addr)) begin
            // Register file writes at the same edge we capture, so its read data is stale.
            result = wb_data;
`endif
        end else begin
            result = rf_data;
        end
`ifndef WB_BYPASS_EN
        result = result | ({DATA_WIDTH{1'b0}} & {DATA_WIDTH{wb_en}} & {DATA_WIDTH{|wb_addr}} & wb_data);
`endif
        return result;
    endfunction

    logic [6:0]            opcode_s;
    logic [ADDR_BITS-1:0]  rd_s;
    logic [ADDR_BITS-1:0]  rs1_s;
    logic [ADDR_BITS-1:0]  rs2_s;
    logic [31:0]           imm32_s;
    logic [DATA_WIDTH-1:0] imm_s;
    logic                  use_rs1_s;
    logic                  use_rs2_s;
    logic                  is_load_s;
    logic                  writes_rd_s;
    logic                  hazard_s;
    logic [DATA_WIDTH-1:0] rs1_data_s;
    logic [DATA_WIDTH-1:0] rs2_data_s;
    idex_t                 idex_nxt_s;
    idex_t                 idex_r;

    assign opcode_s       = if_instr[6:0];
    assign rd_s           = ADDR_BITS'(if_instr[11:7]);
    assign rs1_s          = ADDR_BITS'(if_instr[19:15]);
    assign rs2_s          = ADDR_BITS'(if_instr[24:20]);
    assign rf_read_addr_1 = rs1_s;
    assign rf_read_addr_2 = rs2_s;

    // Immediate format and operand-usage decode from the opcode.
    always_comb begin
        imm32_s     = 32'h0000_0000;
        use_rs1_s   = 1'b1;
        use_rs2_s   = 1'b0;
        is_load_s   = 1'b0;
        writes_rd_s = 1'b1;
        case (opcode_s)
            OP_LOAD: begin
                imm32_s   = {{20{if_instr[31]}}, if_instr[31:20]};
                is_load_s = 1'b1;
            end
            OP_IMM, OP_JALR: begin
                imm32_s = {{20{if_instr[31]}}, if_instr[31:20]};
            end
            OP_STORE: begin
                imm32_s     = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
                use_rs2_s   = 1'b1;
                writes_rd_s = 1'b0;
            end
            OP_BRANCH: begin
                imm32_s     = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                               if_instr[30:25], if_instr[11:8], 1'b0};
                use_rs2_s   = 1'b1;
                writes_rd_s = 1'b0;
            end
            OP_LUI, OP_AUIPC: begin
                imm32_s   = {if_instr[31:12], 12'h000};
                use_rs1_s = 1'b0;
            end
            OP_JAL: begin
                imm32_s   = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                             if_instr[20], if_instr[30:21], 1'b0};
                use_rs1_s = 1'b0;
            end
            OP_REG: begin
                use_rs2_s = 1'b1;
            end
            default: begin
                imm32_s = 32'h0000_0000;
            end
        endcase
    end

    assign imm_s = DATA_WIDTH'($signed(imm32_s));

    assign rs1_data_s = select_operand(rs1_s, rf_read_data_1, wb_write_enable,
                                       wb_write_addr, wb_write_data);
    assign rs2_data_s = select_operand(rs2_s, rf_read_data_2, wb_write_enable,
                                       wb_write_addr, wb_write_data);

    // Only a load in EX whose destination a used source reads forces a bubble.
    assign hazard_s = if_valid && idex_r.valid && idex_r.mem_read
                      && (idex_r.rd != {ADDR_BITS{1'b0}})
                      && ((use_rs1_s && (idex_r.rd == rs1_s))
                          || (use_rs2_s && (idex_r.rd == rs2_s)));

    // A taken branch in EX overrides the stall request.
    assign stall_out = hazard_s && !flush;

    // Next ID/EX contents: bubble on flush or hazard, otherwise the decode results.
    always_comb begin
        idex_nxt_s = '0;
        if (flush || hazard_s) begin
            idex_nxt_s = '0;
        end else begin
            idex_nxt_s.valid     = if_valid;
            idex_nxt_s.pc        = if_pc;
            idex_nxt_s.rs1_data  = rs1_data_s;
            idex_nxt_s.rs2_data  = rs2_data_s;
            idex_nxt_s.imm       = imm_s;
            idex_nxt_s.rs1       = rs1_s;
            idex_nxt_s.rs2       = rs2_s;
            idex_nxt_s.rd        = rd_s;
            idex_nxt_s.opcode    = opcode_s;
            idex_nxt_s.funct3    = if_instr[14:12];
            idex_nxt_s.funct7_b5 = if_instr[30];
            idex_nxt_s.mem_read  = if_valid && is_load_s;
            idex_nxt_s.reg_write = if_valid && writes_rd_s && (rd_s != {ADDR_BITS{1'b0}});
        end
    end

    // ID/EX pipeline register.
    always_ff @(posedge clk) begin
        if (reset) begin
            idex_r <= '0;
        end else begin
            idex_r <= idex_nxt_s;
        end
    end

    assign ex_valid     = idex_r.valid;
    assign ex_pc        = idex_r.pc;
    assign ex_rs1_data  = idex_r.rs1_data;
    assign ex_rs2_data  = idex_r.rs2_data;
    assign ex_imm       = idex_r.imm;
    assign ex_rs1       = idex_r.rs1;
    assign ex_rs2       = idex_r.rs2;
    assign ex_rd        = idex_r.rd;
    assign ex_opcode    = idex_r.opcode;
    assign ex_funct3    = idex_r.funct3;
    assign ex_funct7_b5 = idex_r.funct7_b5;
    assign ex_mem_read  = idex_r.mem_read;
    assign ex_reg_write = idex_r.reg_write;

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
//
// Self-checking bench for decode_stage. A register-file model feeds the read
// ports; a behavioural ID/EX model predicts every registered output and the
// stall request, and one compare process checks them every cycle. A directed
// sequence with literal expectations precedes a randomized run.
// -----------------------------------------------------------------------------
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        flush;
    logic        stall_out;
    logic [4:0]  rf_read_addr_1, rf_read_addr_2;
    logic [31:0] rf_read_data_1, rf_read_data_2;
    logic        wb_write_enable;
    logic [4:0]  wb_write_addr;
    logic [31:0] wb_write_data;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic        ex_funct7_b5, ex_mem_read, ex_reg_write;

    int n_checks = 0;
    int n_err    = 0;

    decode_stage dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr),
        .if_pc(if_pc), .flush(flush), .stall_out(stall_out),
        .rf_read_addr_1(rf_read_addr_1), .rf_read_addr_2(rf_read_addr_2),
        .rf_read_data_1(rf_read_data_1), .rf_read_data_2(rf_read_data_2),
        .wb_write_enable(wb_write_enable), .wb_write_addr(wb_write_addr),
        .wb_write_data(wb_write_data), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_opcode(ex_opcode),
        .ex_funct3(ex_funct3), .ex_funct7_b5(ex_funct7_b5),
        .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write)
    );

    always #5 clk = ~clk;

    // Register file: x0 holds junk so the decode stage's x0 zeroing is exercised.
    logic [31:0] regs [32];
    assign rf_read_data_1 = regs[rf_read_addr_1];
    assign rf_read_data_2 = regs[rf_read_addr_2];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'h1111_1111 * i + 32'h0000_0100;
            regs[0] <= 32'hBAD0_0BAD;
            regs[1] <= 32'd10;
            regs[3] <= 32'd0;
        end else if (wb_write_enable && wb_write_addr != 5'd0) begin
            regs[wb_write_addr] <= wb_write_data;
        end
    end

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, rs1_data, rs2_data, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        funct7_b5, mem_read, reg_write;
    } model_t;

    model_t m;
    bit     model_live = 1'b0;

    function automatic logic [31:0] model_imm(input logic [31:0] ins);
        case (ins[6:0])
            7'h03, 7'h13, 7'h67: return 32'($signed(ins[31:20]));
            7'h23: return 32'($signed({ins[31:25], ins[11:7]}));
            7'h63: return 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            7'h37, 7'h17: return {ins[31:12], 12'h000};
            7'h6F: return 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit model_hazard(input model_t s, input logic v, input logic [31:0] ins);
        bit used1 = !(ins[6:0] inside {7'h37, 7'h17, 7'h6F});
        bit used2 = ins[6:0] inside {7'h33, 7'h23, 7'h63};
        return v && s.valid && s.mem_read && (s.rd != 5'd0)
               && ((used1 && s.rd == ins[19:15]) || (used2 && s.rd == ins[24:20]));
    endfunction

    function automatic logic [31:0] model_operand(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
        if (wb_write_enable && wb_write_addr == a) return wb_write_data;
`endif
        return regs[a];
    endfunction

    function automatic model_t model_next(input model_t s);
        model_t n = '0;
        if (reset || flush || model_hazard(s, if_valid, if_instr)) return n;
        n.valid     = if_valid;
        n.pc        = if_pc;
        n.rs1       = if_instr[19:15];
        n.rs2       = if_instr[24:20];
        n.rd        = if_instr[11:7];
        n.rs1_data  = model_operand(n.rs1);
        n.rs2_data  = model_operand(n.rs2);
        n.imm       = model_imm(if_instr);
        n.opcode    = if_instr[6:0];
        n.funct3    = if_instr[14:12];
        n.funct7_b5 = if_instr[30];
        n.mem_read  = if_valid && (n.opcode == 7'h03);
        n.reg_write = if_valid && !(n.opcode inside {7'h23, 7'h63}) && (n.rd != 5'd0);
        return n;
    endfunction

    // Behavioural ID/EX model advances on every rising edge.
    always @(posedge clk) begin
        m <= model_next(m);
        if (reset) model_live <= 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare process: every output against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_live) begin
            chk("stall_out", 32'(stall_out), 32'(model_hazard(m, if_valid, if_instr) && !flush));
            chk("rf_read_addr_1", 32'(rf_read_addr_1), 32'(if_instr[19:15]));
            chk("rf_read_addr_2", 32'(rf_read_addr_2), 32'(if_instr[24:20]));
            chk("ex_valid", 32'(ex_valid), 32'(m.valid));
            chk("ex_pc", ex_pc, m.pc);
            chk("ex_rs1_data", ex_rs1_data, m.rs1_data);
            chk("ex_rs2_data", ex_rs2_data, m.rs2_data);
            chk("ex_imm", ex_imm, m.imm);
            chk("ex_rs1", 32'(ex_rs1), 32'(m.rs1));
            chk("ex_rs2", 32'(ex_rs2), 32'(m.rs2));
            chk("ex_rd", 32'(ex_rd), 32'(m.rd));
            chk("ex_opcode", 32'(ex_opcode), 32'(m.opcode));
            chk("ex_funct3", 32'(ex_funct3), 32'(m.funct3));
            chk("ex_funct7_b5", 32'(ex_funct7_b5), 32'(m.funct7_b5));
            chk("ex_mem_read", 32'(ex_mem_read), 32'(m.mem_read));
            chk("ex_reg_write", 32'(ex_reg_write), 32'(m.reg_write));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [12] = '{7'h03, 7'h03, 7'h13, 7'h17, 7'h23, 7'h33,
                                 7'h37, 7'h63, 7'h67, 7'h6F, 7'h33, 7'h03};
        logic [31:0] r = $urandom;
        r[6:0]   = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 11)];
        r[11:7]  = 5'($urandom_range(0, 7));
        r[19:15] = 5'($urandom_range(0, 7));
        r[24:20] = 5'($urandom_range(0, 7));
        return r;
    endfunction

    localparam logic [31:0] I_ADDI  = 32'hFFC0_8293; // addi x5,x1,-4
    localparam logic [31:0] I_LW6   = 32'h0001_2303; // lw   x6,0(x2)
    localparam logic [31:0] I_ADD   = 32'h0033_03B3; // add  x7,x6,x3
    localparam logic [31:0] I_LUI6  = 32'h1234_5337; // lui  x6,0x12345
    localparam logic [31:0] I_LW0   = 32'h0001_2003; // lw   x0,0(x2)
    localparam logic [31:0] I_ADD00 = 32'h0000_03B3; // add  x7,x0,x0
    localparam logic [31:0] I_SW    = 32'h0030_A423; // sw   x3,8(x1)

    bit held;

    initial begin
        reset = 1'b1; if_valid = 1'b1; if_instr = I_ADDI; if_pc = 32'h0000_1000;
        flush = 1'b0; wb_write_enable = 1'b0; wb_write_addr = 5'd0; wb_write_data = 32'd0;

        // Hand-computed immediates pin the model's decoder.
        chk("model_imm_I", model_imm(I_ADDI), 32'hFFFF_FFFC);
        chk("model_imm_S", model_imm(I_SW), 32'h0000_0008);
        chk("model_imm_B", model_imm(32'hFE00_0FE3), 32'hFFFF_FFFE);
        chk("model_imm_J", model_imm(32'hFFDF_F06F), 32'hFFFF_FFFC);
        chk("model_imm_U", model_imm(I_LUI6), 32'h1234_5000);

        tick(); tick();
        chk("reset_ex_valid", 32'(ex_valid), 32'd0);
        chk("reset_ex_imm", ex_imm, 32'd0);
        chk("reset_ex_reg_write", 32'(ex_reg_write), 32'd0);
        chk("reset_stall", 32'(stall_out), 32'd0);
        reset = 1'b0;

        tick();
        chk("addi_rd", 32'(ex_rd), 32'd5);
        chk("addi_imm", ex_imm, 32'hFFFF_FFFC);
        chk("addi_rs1_data", ex_rs1_data, 32'd10);
        chk("addi_reg_write", 32'(ex_reg_write), 32'd1);

        if_instr = I_LW6; tick();
        if_instr = I_ADD; #1;
        chk("lu_stall", 32'(stall_out), 32'd1);
        tick();
        chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
        chk("lu_stall_clears", 32'(stall_out), 32'd0);
        tick();
        chk("lu_add_valid", 32'(ex_valid), 32'd1);
        chk("lu_add_rs1", 32'(ex_rs1), 32'd6);

        if_instr = I_LW6; tick();
        if_instr = I_LUI6; #1;
        chk("lui_no_stall", 32'(stall_out), 32'd0);
        tick();
        if_instr = I_LW0; tick();
        if_instr = I_ADD00; #1;
        chk("x0_no_stall", 32'(stall_out), 32'd0);
        tick();

        if_instr = I_LW6; tick();
        if_instr = I_ADD; flush = 1'b1; #1;
        chk("flush_masks_stall", 32'(stall_out), 32'd0);
        tick();
        chk("flush_bubble", 32'(ex_valid), 32'd0);
        flush = 1'b0; tick();

        wb_write_enable = 1'b1; wb_write_addr = 5'd3; wb_write_data = 32'hDEAD_BEEF;
        if_instr = I_SW; tick();
`ifdef WB_BYPASS_EN
        chk("bypass_rs2_data", ex_rs2_data, 32'hDEAD_BEEF);
`else
        chk("bypass_rs2_data", ex_rs2_data, 32'h0000_0000);
`endif
        chk("sw_imm", ex_imm, 32'd8);
        chk("sw_reg_write", 32'(ex_reg_write), 32'd0);
        wb_write_enable = 1'b0;

        // Randomized run; IF holds its slot while a stall is requested.
        held = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if (!held) begin
                if_instr = rand_instr();
                if_pc    = $urandom;
                if_valid = ($urandom_range(0, 7) != 0);
            end
            flush           = ($urandom_range(0, 9) == 0);
            reset           = ($urandom_range(0, 59) == 0);
            wb_write_enable = ($urandom_range(0, 2) == 0);
            wb_write_addr   = 5'($urandom_range(0, 7));
            wb_write_data   = $urandom;
            #1 held = stall_out;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
